// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared arbiter state encoding and AXI response codes
package axi4_lite_pkg;
  typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP} arb_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// axi4_lite_rr_arbiter: one-hot grant picker, round-robin by default or fixed priority with AXI_ARB_FIXED_PRIO_EN
module axi4_lite_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] base, pick, idx;
  logic found;
`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{ACLK, ARESET, upd};
  // starting one past the last index makes the scan begin at requester 0
  assign base = IW'(NUM_REQ - 1);
`else
  logic [IW-1:0] last_q, held_q;
  assign base = last_q;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_q <= IW'(NUM_REQ - 1);
      held_q <= '0;
    end else begin
      if (|grant) held_q <= pick;
      if (upd) last_q <= held_q;
    end
  end
`endif
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(base) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign grant = (en && found) ? NUM_REQ'(1) << pick : '0;
endmodule

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: shares one AXI4-Lite master port among NUM_REQ requesters
// Grant policy selected by AXI_ARB_FIXED_PRIO_EN (fixed priority) or round-robin when undefined.
module axi4_lite_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_WRITE,
  input  logic [NUM_REQ*ADDRESS-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [NUM_REQ*4-1:0]          REQ_WSTRB,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic [ADDRESS-1:0]            M_AWADDR,
  output logic                          M_AWVALID,
  input  logic                          M_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_WDATA,
  output logic [3:0]                    M_WSTRB,
  output logic                          M_WVALID,
  input  logic                          M_WREADY,
  input  logic [1:0]                    M_BRESP,
  input  logic                          M_BVALID,
  output logic                          M_BREADY,
  output logic [ADDRESS-1:0]            M_ARADDR,
  output logic                          M_ARVALID,
  input  logic                          M_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_RDATA,
  input  logic [1:0]                    M_RRESP,
  input  logic                          M_RVALID,
  output logic                          M_RREADY
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, nstate;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] gidx, owner_q;
  logic [ADDRESS-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic [1:0] resp_q;
  logic aw_done, w_done;
  axi4_lite_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .req(REQ_VALID),
    .en(state == IDLE),
    .upd(state == RESP),
    .grant(grant)
  );
  assign REQ_READY = grant;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) gidx = grant[i] ? IW'(i) : gidx;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE:       nstate = |grant ? (REQ_WRITE[gidx] ? WADDR_DATA : RADDR) : IDLE;
      WADDR_DATA: nstate = ((aw_done || M_AWREADY) && (w_done || M_WREADY)) ? WRESP : WADDR_DATA;
      WRESP:      nstate = M_BVALID ? RESP : WRESP;
      RADDR:      nstate = M_ARREADY ? RDATA : RADDR;
      RDATA:      nstate = M_RVALID ? RESP : RDATA;
      default:    nstate = IDLE;
    endcase
  end
  always_comb begin
    M_AWVALID = (state == WADDR_DATA) && !aw_done;
    M_WVALID = (state == WADDR_DATA) && !w_done;
    M_BREADY = state == WRESP;
    M_ARVALID = state == RADDR;
    M_RREADY = state == RDATA;
    RSP_VALID = (state == RESP) ? NUM_REQ'(1) << owner_q : '0;
    RSP_RDATA = (state == RESP) ? rdata_q : '0;
    RSP_RESP = (state == RESP) ? resp_q : RESP_OKAY;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      owner_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rdata_q <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      if (state == IDLE && |grant) begin
        owner_q <= gidx;
        addr_q <= REQ_ADDR[gidx*ADDRESS +: ADDRESS];
        wdata_q <= REQ_WDATA[gidx*DATA_WIDTH +: DATA_WIDTH];
        wstrb_q <= REQ_WSTRB[gidx*4 +: 4];
        aw_done <= 1'b0;
        w_done <= 1'b0;
        rdata_q <= '0;
        resp_q <= RESP_OKAY;
      end
      if (state == WADDR_DATA) begin
        aw_done <= aw_done | M_AWREADY;
        w_done <= w_done | M_WREADY;
      end
      if (state == WRESP && M_BVALID) resp_q <= M_BRESP;
      if (state == RDATA && M_RVALID) begin
        rdata_q <= M_RDATA;
        resp_q <= M_RRESP;
      end
    end
  end
  assign M_AWADDR = addr_q;
  assign M_ARADDR = addr_q;
  assign M_WDATA = wdata_q;
  assign M_WSTRB = wstrb_q;
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: directed self-checking bench with a delay-configurable AXI4-Lite slave model
module tb_axi4_lite_arbiter;
  import axi4_lite_pkg::*;
  localparam int N = 2, AW = 32, DW = 32;
`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [N-1:0] REQ_VALID, REQ_WRITE, REQ_READY, RSP_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA;
  logic [N*4-1:0] REQ_WSTRB;
  logic [DW-1:0] RSP_RDATA, M_WDATA, M_RDATA;
  logic [1:0] RSP_RESP, M_BRESP, M_RRESP;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic [3:0] M_WSTRB;
  logic M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  int checks = 0, failures = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0] resp_cfg = RESP_OKAY;
  logic [31:0] mem [16];

  axi4_lite_arbiter #(.ADDRESS(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // slave: each ready/valid fires after its configured number of wait cycles
  assign M_AWREADY = M_AWVALID && aw_cnt >= aw_dly;
  assign M_WREADY = M_WVALID && w_cnt >= w_dly;
  assign M_BVALID = M_BREADY;
  assign M_BRESP = resp_cfg;
  assign M_ARREADY = M_ARVALID && ar_cnt >= ar_dly;
  assign M_RVALID = M_RREADY && r_cnt >= r_dly;
  assign M_RDATA = mem[M_ARADDR[3:0]];
  assign M_RRESP = resp_cfg;
  always @(posedge ACLK) begin
    aw_cnt <= (M_AWVALID && !M_AWREADY) ? aw_cnt + 1 : 0;
    w_cnt <= (M_WVALID && !M_WREADY) ? w_cnt + 1 : 0;
    ar_cnt <= (M_ARVALID && !M_ARREADY) ? ar_cnt + 1 : 0;
    r_cnt <= (M_RREADY && !M_RVALID) ? r_cnt + 1 : 0;
    if (ARESET) for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
    else if (M_BVALID) mem[M_AWADDR[3:0]] <= M_WDATA;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    REQ_VALID[r] = 1'b1;
    REQ_WRITE[r] = wr;
    REQ_ADDR[r*AW +: AW] = a;
    REQ_WDATA[r*DW +: DW] = d;
    REQ_WSTRB[r*4 +: 4] = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, g;
    REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    repeat (3) cyc();
    chk("rst_req_ready", REQ_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
    chk("rst_araddr", M_ARADDR, 0);
    ARESET = 1'b0;
    cyc();
    // contention: both requesters hold read commands continuously
    set_req(0, 1'b0, 32'd1, 0);
    set_req(1, 1'b0, 32'd2, 0);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = FIXED ? 0 : k % 2;
      n = 0;
      while (REQ_READY == 0 && n < 10) begin cyc(); n++; end
      chk("cont_grant", REQ_READY, 64'(1) << g);
      repeat (3) cyc();
      chk("cont_rsp", RSP_VALID, 64'(1) << g);
      chk("cont_rdata", RSP_RDATA, 32'h101 + g);
      chk("cont_noready_in_rsp", REQ_READY, 0);
      if (k == 3) REQ_VALID = '0;
      cyc();
    end
    // single write then read back
    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
    #1;
    chk("wr_ready", REQ_READY, 1);
    cyc();
    REQ_VALID = '0;
    chk("wr_aw_w_valid", {M_AWVALID, M_WVALID}, 2'b11);
    chk("wr_awaddr", M_AWADDR, 5);
    chk("wr_wdata", M_WDATA, 32'hDEADBEEF);
    chk("wr_wstrb", M_WSTRB, 4'hF);
    cyc();
    chk("wr_bready", {M_BREADY, M_AWVALID, M_WVALID}, 3'b100);
    cyc();
    chk("wr_rsp", RSP_VALID, 1);
    chk("wr_resp", RSP_RESP, RESP_OKAY);
    chk("wr_rdata_zero", RSP_RDATA, 0);
    cyc();
    chk("wr_rsp_pulse", RSP_VALID, 0);
    set_req(0, 1'b0, 32'd5, 0);
    #1;
    chk("rb_ready", REQ_READY, 1);
    cyc();
    REQ_VALID = '0;
    chk("rb_arvalid", M_ARVALID, 1);
    chk("rb_araddr", M_ARADDR, 5);
    cyc();
    chk("rb_rready", M_RREADY, 1);
    cyc();
    chk("rb_rsp", RSP_VALID, 1);
    chk("rb_rdata", RSP_RDATA, 32'hDEADBEEF);
    cyc();
    // slave error response is passed through unmodified
    resp_cfg = RESP_SLVERR;
    set_req(1, 1'b1, 32'd9, 32'hCAFE);
    #1;
    chk("err_ready", REQ_READY, 2);
    cyc();
    REQ_VALID = '0;
    repeat (2) cyc();
    chk("err_rsp", RSP_VALID, 2);
    chk("err_resp", RSP_RESP, RESP_SLVERR);
    resp_cfg = RESP_OKAY;
    cyc();
    // skewed write: AW accepted at once, W after 3 wait cycles
    w_dly = 3;
    set_req(0, 1'b1, 32'd7, 32'h12345678);
    #1;
    chk("sk_ready", REQ_READY, 1);
    cyc();
    REQ_VALID = '0;
    chk("sk_c1", {M_AWVALID, M_AWREADY, M_WVALID, M_WREADY}, 4'b1110);
    cyc();
    chk("sk_c2", {M_AWVALID, M_WVALID, M_BREADY}, 3'b010);
    repeat (2) cyc();
    chk("sk_c4", {M_WVALID, M_WREADY, M_BREADY}, 3'b110);
    cyc();
    chk("sk_c5", {M_WVALID, M_BREADY}, 2'b01);
    cyc();
    chk("sk_rsp", RSP_VALID, 1);
    w_dly = 0;
    cyc();
    // read backpressure: ARREADY after 3 waits, RVALID after 2 more
    ar_dly = 3;
    r_dly = 2;
    set_req(0, 1'b0, 32'd7, 0);
    #1;
    chk("bp_ready", REQ_READY, 1);
    cyc();
    REQ_VALID = '0;
    chk("bp_araddr_first", M_ARADDR, 7);
    repeat (3) cyc();
    chk("bp_araddr_last", M_ARADDR, 7);
    chk("bp_ar_hs", {M_ARVALID, M_ARREADY, RSP_VALID}, 4'b1100);
    cyc();
    chk("bp_rready", {M_RREADY, M_ARVALID}, 2'b10);
    repeat (3) cyc();
    chk("bp_rsp", RSP_VALID, 1);
    chk("bp_rdata", RSP_RDATA, 32'h12345678);
    cyc();
    chk("bp_rsp_pulse", {RSP_VALID, RSP_RDATA}, 0);
    ar_dly = 0;
    // reset while waiting in the read-data phase
    r_dly = 5;
    set_req(1, 1'b0, 32'd3, 0);
    #1;
    chk("rr_ready", REQ_READY, 2);
    cyc();
    REQ_VALID = '0;
    cyc();
    chk("rr_in_rdata", M_RREADY, 1);
    ARESET = 1'b1;
    cyc();
    chk("rr_outputs", {REQ_READY, RSP_VALID, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
    chk("rr_araddr", M_ARADDR, 0);
    ARESET = 1'b0;
    r_dly = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_no_rsp", RSP_VALID, 0);
    end
    set_req(0, 1'b0, 32'd4, 0);
    set_req(1, 1'b0, 32'd3, 0);
    #1;
    chk("rr_post_grant", REQ_READY, 1);
    cyc();
    REQ_VALID = '0;
    repeat (2) cyc();
    chk("rr_post_rsp", RSP_VALID, 1);
    chk("rr_post_rdata", RSP_RDATA, 32'h104);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_arbiter.md
# axi4_lite_arbiter

Shares one AXI4-Lite slave port between NUM_REQ simple requesters. Each requester issues single read or write commands on a valid/ready command port and gets a one-cycle response pulse. The arbiter grants one requester at a time, round-robin, and runs the full AXI4-Lite write (AW+W→B) or read (AR→R) handshake on the master side. It sits between the core-side requesters and axi4_lite_slave.

## Interface
- ADDRESS, 32, AXI address width
- DATA_WIDTH, 32, AXI data width
- NUM_REQ, 2, number of requesters (≥2)
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- REQ_VALID  in  NUM_REQ  per-requester command valid
- REQ_WRITE  in  NUM_REQ  1=write, 0=read
- REQ_ADDR  in  NUM_REQ*ADDRESS  flattened addresses, requester i at [i*ADDRESS +: ADDRESS]
- REQ_WDATA  in  NUM_REQ*DATA_WIDTH  flattened write data
- REQ_WSTRB  in  NUM_REQ*4  flattened write strobes
- REQ_READY  out  NUM_REQ  one-hot command accept pulse
- RSP_VALID  out  NUM_REQ  one-hot response pulse to the owner
- RSP_RDATA  out  DATA_WIDTH  read data, valid with RSP_VALID (0 for writes)
- RSP_RESP  out  2  captured RRESP/BRESP, valid with RSP_VALID
- M_AWADDR/M_AWVALID/M_AWREADY, M_WDATA/M_WSTRB/M_WVALID/M_WREADY, M_BRESP/M_BVALID/M_BREADY, M_ARADDR/M_ARVALID/M_ARREADY, M_RDATA/M_RRESP/M_RVALID/M_RREADY  standard AXI4-Lite master channels, widths ADDRESS/DATA_WIDTH/4/2/1

## Operation
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP.
- IDLE: if any REQ_VALID, the arbiter picks winner g and asserts REQ_READY[g] combinationally in that cycle. It latches addr, wdata, wstrb, write and owner=g. The FSM then goes to WADDR_DATA if write, else RADDR.
- WADDR_DATA: M_AWVALID and M_WVALID are driven independently. Flags aw_done and w_done are set on their handshakes, and each VALID drops once its flag is set. The FSM goes to WRESP when both are done, including both in the same cycle.
- WRESP: M_BREADY=1. On M_BVALID it captures M_BRESP and goes to RESP.
- RADDR: M_ARVALID=1. On M_ARREADY it goes to RDATA.
- RDATA: M_RREADY=1. On M_RVALID it captures M_RDATA and M_RRESP and goes to RESP.
- RESP: RSP_VALID[owner]=1 for exactly one cycle, and the round-robin pointer is updated to owner. The FSM then returns to IDLE.
- Round-robin: the search starts at last_grant+1 modulo NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- Requester rule: REQ_VALID and its payload are held until REQ_READY. Commands arriving while busy wait, and arbitration happens only in IDLE.
- Address and data outputs come from latched registers and are stable while VALID is high.
- Response data is passed through unmodified. No response-code checking is done.

## Timing
- Reset: all outputs 0, state=IDLE, flags cleared, last_grant=NUM_REQ-1.
- ARESET mid-transaction: next edge forces IDLE and all VALID/READY to 0. The in-flight command is dropped and no RSP_VALID is issued.
- With a zero-wait slave, RSP_VALID is asserted 3 cycles after the REQ_READY cycle for both reads and writes. Each slave wait cycle adds one cycle.
- At least one IDLE cycle separates consecutive transactions. Back-to-back throughput is 1 transaction per 4 cycles minimum.
- Simultaneous REQ_VALID from all requesters: grants rotate 0,1,…,NUM_REQ-1,0.
- REQ_READY and RSP_VALID are never asserted to two requesters in the same cycle.

## Configuration
- AXI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. last_grant is neither updated nor used.
- Undefined (default): round-robin as above.

## Structure
- axi4_lite_pkg:
  - arbiter state enum
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
- Sub-module axi4_lite_rr_arbiter:
  - inputs: request vector, enable, update strobe
  - outputs: one-hot grant
  - holds last_grant
  - implements the AXI_ARB_FIXED_PRIO_EN switch

## Test plan
- Single write: req0 write addr=5 data=0xDEADBEEF strb=0xF → M_AWADDR=5 and M_WDATA=0xDEADBEEF handshaken, then RSP_VALID[0] with RSP_RESP=0. A later read of addr 5 returns RSP_RDATA=0xDEADBEEF.
- Contention: req0 and req1 both valid reading addrs 1 and 2 → req0 granted first and RSP_VALID[0] seen before REQ_READY[1]. With both held continuously, grants alternate 0,1,0,1.
- Skewed write handshake: slave gives AWREADY at cycle 1 and WREADY at cycle 4 → AWVALID drops after cycle 1, WVALID stays high until cycle 4, and M_BREADY rises only after both.
- Read backpressure: ARREADY delayed 3 cycles and RVALID delayed 2 more → M_ARADDR stable throughout, and RSP_VALID is a single-cycle pulse carrying the captured RDATA.
- Reset mid-read: ARESET asserted in RDATA → next cycle all outputs 0 and no RSP_VALID. The next request is granted to requester 0.
- AXI_ARB_FIXED_PRIO_EN build: req0 and req1 permanently valid → req0 wins every arbitration.
